dcache_load_responder: RTL and testbench
========================================

# dcache_load_responder

Responder side of the load-data/cache request interface. Each cycle it answers the load data stage's single load request combinationally: hit data with byte masks, or an MSHR index for a miss. It owns a small direct-mapped load cache and an MSHR file, issues block reads to memory, and broadcasts MSHR fills to the load buffer.

## Interface
Parameters:
- `LINES`, 32: direct-mapped lines, 8-byte (2-word) blocks.
- `MSHRS`, 4: MSHR entries; the `mshr_idx` width is clog2(MSHRS).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load_req_valid`  in  1  load request present.
- `load_req_addr`  in  ADDR(32)  byte address; block = addr[31:3], word = addr[2] (`dw.w_idx`).
- `load_data_cache_packet`  out  LOAD_DATA_CACHE_PACKET  {valid, mshr_idx, byte_mask[2][4], data[2]}.
- `mem_command`  out  MEM_COMMAND  MEM_NONE / MEM_LOAD.
- `mem_addr`  out  ADDR  block-aligned read address.
- `mem_req_tag`  in  MEM_TAG(4)  transaction tag for the current request; 0 = rejected.
- `mem_data_tag`  in  MEM_TAG(4)  returning-data tag; 0 = none.
- `mem_data`  in  MEM_BLOCK(64)  returning block.
- `fill_packet`  out  MSHR_FILL_PACKET  {valid, mshr_idx, data[2]} to the load buffer.

## Operation
- Lookup: index = addr[3 +: log2(LINES)]; tag = the remaining upper bits. Hit = line valid and tags match.
- Response, evaluated in priority order when `load_req_valid`=1:
  - Bypass: `mem_data_tag`≠0 matches a WAIT MSHR for this block. valid=1, data=`mem_data`, both byte_masks=4'hF.
  - Hit: valid=1, data = line data, both byte_masks=4'hF, mshr_idx=0.
  - Merge: a PENDING or WAIT MSHR holds this block. valid=1, mshr_idx=that entry, byte_masks=0.
  - Allocate: lowest-index FREE entry. valid=1, mshr_idx=that entry, byte_masks=0; the entry becomes PENDING at the edge.
  - Otherwise valid=0. The load stage stalls and retries.
- `load_req_valid`=0 gives valid=0 and no state change.
- MSHR states:
  - FREE→PENDING on allocate.
  - PENDING→WAIT when it is the issuing entry and `mem_req_tag`≠0; the tag is stored.
  - WAIT→FREE when `mem_data_tag` equals the stored tag.
- Issue: the lowest-index PENDING entry drives `mem_command`=MEM_LOAD and `mem_addr`={block,3'b0}. On reject it holds the same request the next cycle. With no PENDING entry, MEM_NONE.
- Fill: a matching `mem_data_tag` produces `fill_packet.valid`=1 with that mshr_idx and data in the same cycle. At the edge the line is written, valid set, tag updated (overwriting any prior line), and the entry is freed.
- Free-ness is computed from registered state. An entry freed this cycle cannot be allocated until the next cycle.
- Tags with no matching WAIT entry are ignored. Memory guarantees distinct outstanding tags.

## Timing
- Response: combinational, 0-cycle; allocation is visible from the next cycle.
- Earliest request: the cycle after allocation.
- Fill broadcast: same cycle as data return.
- A hit on the filled line is possible from the cycle after the fill.
- Reset (async assert, sync deassert at use): all MSHRs FREE, all lines invalid.
- Output values during reset:
  - `load_data_cache_packet.valid`=0
  - `mem_command`=MEM_NONE
  - `mem_addr`=0
  - `fill_packet.valid`=0
- Reset mid-transaction: all in-flight state is dropped, and later data for stale tags is ignored.

## Structure
- sys_defs.svh additions:
  - LOAD_DATA_CACHE_PACKET and MSHR_FILL_PACKET
  - MSHR_STATE enum {MSHR_FREE, MSHR_PENDING, MSHR_WAIT}
  - MSHR_IDX
  - NOP_MSHR_FILL_PACKET
- Existing types reused: MEM_TAG, MEM_BLOCK, MEM_COMMAND, ADDR.
- One sub-module, `mshr_file`: entry state, block, tag, allocate/merge/issue/free logic. Lines and lookup stay in the top.

## Test plan
- Miss then hit:
  - After reset, request 0x100 → valid=1, mshr_idx=0, masks=0.
  - Next cycle MEM_LOAD 0x100; answer tag 3.
  - Data tag 3, 0x1122334455667788 → fill valid, idx 0.
  - Next cycle request 0x104 → hit, data[1]=0x11223344, masks=4'hF.
- Merge: miss 0x200 → idx 0; next cycle 0x204 → idx 0; exactly one MEM_LOAD is issued.
- Full:
  - Misses 0x000, 0x008, 0x010, 0x018 → idx 0..3; 0x020 → valid=0.
  - Fill idx 1; in the same cycle 0x020 still gives valid=0; the next cycle it gives idx 1.
- Reject: `mem_req_tag`=0 for 3 cycles → MEM_LOAD 0x300 held steady; tag 5 on cycle 4 → MEM_NONE the next cycle.
- Bypass: request 0x108 in the same cycle its tag returns with 0xAABBCCDD_EEFF0011 → valid=1, masks=4'hF, data[1]=0xAABBCCDD.
- Reset mid-operation:
  - Reset asserted with an entry in WAIT (tag 7) → all outputs go to reset values immediately.
  - After release, data tag 7 → `fill_packet.valid`=0 and line invalid.

Source files
------------

// File: rtl/dcache_load_responder_pkg.sv
// ----------------------------------------------------------------------------
// dcache_load_responder_pkg
// Shared types for the load responder: memory-side types, MSHR state and
// index, and the packets exchanged with the load data stage and load buffer.
// ----------------------------------------------------------------------------
package dcache_load_responder_pkg;

    localparam int N_LINES = 32;
    localparam int N_MSHRS = 4;
    // Byte address minus the 3 offset bits of an 8-byte block.
    localparam int BLOCK_W = 29;

    typedef logic [31:0]        ADDR;
    typedef logic [3:0]         MEM_TAG;
    typedef logic [63:0]        MEM_BLOCK;
    typedef logic [BLOCK_W-1:0] BLOCK_ADDR;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LOAD = 2'd1
    } MEM_COMMAND;

    typedef enum logic [1:0] {
        MSHR_FREE    = 2'd0,
        MSHR_PENDING = 2'd1,
        MSHR_WAIT    = 2'd2
    } MSHR_STATE;

    typedef logic [$clog2(N_MSHRS)-1:0] MSHR_IDX;

    // data[1] is the upper word of the block (addr[2] = 1).
    typedef struct packed {
        logic              valid;
        MSHR_IDX           mshr_idx;
        logic [1:0][3:0]   byte_mask;
        logic [1:0][31:0]  data;
    } LOAD_DATA_CACHE_PACKET;

    typedef struct packed {
        logic              valid;
        MSHR_IDX           mshr_idx;
        logic [1:0][31:0]  data;
    } MSHR_FILL_PACKET;

    localparam MSHR_FILL_PACKET NOP_MSHR_FILL_PACKET = '0;

    // Block number of a byte address.
    function automatic BLOCK_ADDR block_of(input ADDR addr);
        return addr[31:3];
    endfunction

endpackage

// File: rtl/dcache_load_responder_mshr_file.sv
// ----------------------------------------------------------------------------
// mshr_file
// Miss status holding registers. Each entry is FREE, PENDING (waiting to be
// sent to memory) or WAIT (sent, holding its memory tag). All lookups are
// made from registered state.
// Ports:
//   clock, reset        clock, async active-low reset
//   i_req_block         block of the current load request (merge lookup)
//   i_alloc_en          allocate the lowest FREE entry for i_req_block
//   i_mem_req_tag       memory acceptance tag for the issuing entry (0 = reject)
//   i_mem_data_tag      returning data tag (0 = none)
//   o_merge_hit/_idx    a PENDING/WAIT entry already holds i_req_block
//   o_free_found/_idx   lowest FREE entry
//   o_issue_valid/_block lowest PENDING entry, to be sent to memory
//   o_fill_valid/_idx/_block WAIT entry whose tag matches i_mem_data_tag
// ----------------------------------------------------------------------------
module mshr_file
    import dcache_load_responder_pkg::*;
#(
    parameter int MSHRS = N_MSHRS
) (
    input  logic      clock,
    input  logic      reset,
    input  BLOCK_ADDR i_req_block,
    input  logic      i_alloc_en,
    input  MEM_TAG    i_mem_req_tag,
    input  MEM_TAG    i_mem_data_tag,
    output logic      o_merge_hit,
    output MSHR_IDX   o_merge_idx,
    output logic      o_free_found,
    output MSHR_IDX   o_free_idx,
    output logic      o_issue_valid,
    output BLOCK_ADDR o_issue_block,
    output logic      o_fill_valid,
    output MSHR_IDX   o_fill_idx,
    output BLOCK_ADDR o_fill_block
);

    MSHR_STATE r_state [MSHRS];
    BLOCK_ADDR r_block [MSHRS];
    MEM_TAG    r_tag   [MSHRS];

    MSHR_IDX   w_issue_idx;

    // Priority searches; scanning downward lets the lowest index win.
    always_comb begin
        o_merge_hit   = 1'b0;
        o_merge_idx   = '0;
        o_free_found  = 1'b0;
        o_free_idx    = '0;
        o_issue_valid = 1'b0;
        w_issue_idx   = '0;
        o_issue_block = '0;
        o_fill_valid  = 1'b0;
        o_fill_idx    = '0;
        o_fill_block  = '0;
        for (int i = MSHRS - 1; i >= 0; i--) begin
            if (r_state[i] != MSHR_FREE && r_block[i] == i_req_block) begin
                o_merge_hit = 1'b1;
                o_merge_idx = MSHR_IDX'(i);
            end else begin
                o_merge_hit = o_merge_hit;
            end
            if (r_state[i] == MSHR_FREE) begin
                o_free_found = 1'b1;
                o_free_idx   = MSHR_IDX'(i);
            end else begin
                o_free_found = o_free_found;
            end
            if (r_state[i] == MSHR_PENDING) begin
                o_issue_valid = 1'b1;
                w_issue_idx   = MSHR_IDX'(i);
                o_issue_block = r_block[i];
            end else begin
                o_issue_valid = o_issue_valid;
            end
            // Memory guarantees distinct outstanding tags, so at most one match.
            if (r_state[i] == MSHR_WAIT && i_mem_data_tag != 4'd0 &&
                r_tag[i] == i_mem_data_tag) begin
                o_fill_valid = 1'b1;
                o_fill_idx   = MSHR_IDX'(i);
                o_fill_block = r_block[i];
            end else begin
                o_fill_valid = o_fill_valid;
            end
        end
    end

    // Per-entry state transitions: allocate, accept by memory, free on fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSHRS; i++) begin
                r_state[i] <= MSHR_FREE;
                r_block[i] <= '0;
                r_tag[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < MSHRS; i++) begin
                case (r_state[i])
                    MSHR_FREE: begin
                        if (i_alloc_en && o_free_idx == MSHR_IDX'(i)) begin
                            r_state[i] <= MSHR_PENDING;
                            r_block[i] <= i_req_block;
                        end
                    end
                    MSHR_PENDING: begin
                        if (o_issue_valid && w_issue_idx == MSHR_IDX'(i) &&
                            i_mem_req_tag != 4'd0) begin
                            r_state[i] <= MSHR_WAIT;
                            r_tag[i]   <= i_mem_req_tag;
                        end
                    end
                    MSHR_WAIT: begin
                        if (i_mem_data_tag != 4'd0 && r_tag[i] == i_mem_data_tag) begin
                            r_state[i] <= MSHR_FREE;
                        end
                    end
                    default: r_state[i] <= MSHR_FREE;
                endcase
            end
        end
    end

endmodule

// File: rtl/dcache_load_responder.sv
// ----------------------------------------------------------------------------
// dcache_load_responder
// Answers the load data stage's single load request in the same cycle: hit
// data (from the line array or bypassed from returning memory data) or an
// MSHR index for a miss. Owns a direct-mapped line array and an MSHR file,
// issues block reads to memory and broadcasts fills to the load buffer.
// Ports:
//   clock, reset                 clock, async active-low reset
//   load_req_valid/_addr         load request and byte address
//   load_data_cache_packet       combinational response
//   mem_command, mem_addr        block read request to memory
//   mem_req_tag                  acceptance tag for this request (0 = reject)
//   mem_data_tag, mem_data       returning block and its tag (0 = none)
//   fill_packet                  fill broadcast to the load buffer
// ----------------------------------------------------------------------------
module dcache_load_responder
    import dcache_load_responder_pkg::*;
#(
    parameter int LINES = N_LINES,
    parameter int MSHRS = N_MSHRS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req_valid,
    input  ADDR                   load_req_addr,
    output LOAD_DATA_CACHE_PACKET load_data_cache_packet,
    output MEM_COMMAND            mem_command,
    output ADDR                   mem_addr,
    input  MEM_TAG                mem_req_tag,
    input  MEM_TAG                mem_data_tag,
    input  MEM_BLOCK              mem_data,
    output MSHR_FILL_PACKET       fill_packet
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = BLOCK_W - IDX_W;

    logic [LINES-1:0] r_line_valid;
    logic [TAG_W-1:0] r_line_tag  [LINES];
    MEM_BLOCK         r_line_data [LINES];

    BLOCK_ADDR        w_req_block;
    logic [IDX_W-1:0] w_req_index;
    logic [TAG_W-1:0] w_req_tag;
    logic             w_hit;
    logic             w_bypass;
    logic             w_alloc_en;
    logic             w_merge_hit;
    MSHR_IDX          w_merge_idx;
    logic             w_free_found;
    MSHR_IDX          w_free_idx;
    logic             w_issue_valid;
    BLOCK_ADDR        w_issue_block;
    logic             w_fill_valid;
    MSHR_IDX          w_fill_idx;
    BLOCK_ADDR        w_fill_block;
    logic [IDX_W-1:0] w_fill_index;
    logic             w_unused_addr_lo;
    LOAD_DATA_CACHE_PACKET w_resp;

    // Whole block is returned with both masks, so the offset bits are not needed.
    assign w_unused_addr_lo = ^load_req_addr[2:0];

    assign w_req_block  = block_of(load_req_addr);
    assign w_req_index  = w_req_block[IDX_W-1:0];
    assign w_req_tag    = w_req_block[BLOCK_W-1:IDX_W];
    assign w_fill_index = w_fill_block[IDX_W-1:0];

    assign w_hit    = r_line_valid[w_req_index] && (r_line_tag[w_req_index] == w_req_tag);
    assign w_bypass = w_fill_valid && (w_fill_block == w_req_block);

    mshr_file #(.MSHRS(MSHRS)) u_mshr_file (
        .clock          (clock),
        .reset          (reset),
        .i_req_block    (w_req_block),
        .i_alloc_en     (w_alloc_en),
        .i_mem_req_tag  (mem_req_tag),
        .i_mem_data_tag (mem_data_tag),
        .o_merge_hit    (w_merge_hit),
        .o_merge_idx    (w_merge_idx),
        .o_free_found   (w_free_found),
        .o_free_idx     (w_free_idx),
        .o_issue_valid  (w_issue_valid),
        .o_issue_block  (w_issue_block),
        .o_fill_valid   (w_fill_valid),
        .o_fill_idx     (w_fill_idx),
        .o_fill_block   (w_fill_block)
    );

    // Response priority: bypass, hit, merge, allocate; otherwise stall.
    // Gated by reset so outputs read idle while reset is held.
    always_comb begin
        w_resp     = '0;
        w_alloc_en = 1'b0;
        if (reset && load_req_valid) begin
            if (w_bypass) begin
                w_resp.valid     = 1'b1;
                w_resp.mshr_idx  = w_fill_idx;
                w_resp.byte_mask = {4'hF, 4'hF};
                w_resp.data      = mem_data;
            end else if (w_hit) begin
                w_resp.valid     = 1'b1;
                w_resp.byte_mask = {4'hF, 4'hF};
                w_resp.data      = r_line_data[w_req_index];
            end else if (w_merge_hit) begin
                w_resp.valid     = 1'b1;
                w_resp.mshr_idx  = w_merge_idx;
            end else if (w_free_found) begin
                w_resp.valid     = 1'b1;
                w_resp.mshr_idx  = w_free_idx;
                w_alloc_en       = 1'b1;
            end else begin
                w_resp.valid     = 1'b0;
            end
        end else begin
            w_resp.valid = 1'b0;
        end
    end

    assign load_data_cache_packet = w_resp;
    assign mem_command = (reset && w_issue_valid) ? MEM_LOAD : MEM_NONE;
    assign mem_addr    = (reset && w_issue_valid) ? {w_issue_block, 3'b000} : 32'd0;

    // Fill broadcast in the same cycle as the data return.
    always_comb begin
        fill_packet = NOP_MSHR_FILL_PACKET;
        if (reset && w_fill_valid) begin
            fill_packet.valid    = 1'b1;
            fill_packet.mshr_idx = w_fill_idx;
            fill_packet.data     = mem_data;
        end else begin
            fill_packet.valid    = 1'b0;
        end
    end

    // Line valid bits: cleared on reset, set by a fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_line_valid <= '0;
        end else if (w_fill_valid) begin
            r_line_valid[w_fill_index] <= 1'b1;
        end
    end

    // Line tag/data: a fill overwrites whatever the line held.
    always_ff @(posedge clock) begin
        if (w_fill_valid) begin
            r_line_tag[w_fill_index]  <= w_fill_block[BLOCK_W-1:IDX_W];
            r_line_data[w_fill_index] <= mem_data;
        end
    end

endmodule

// File: tb/tb_dcache_load_responder.sv
module tb_dcache_load_responder;
    import dcache_load_responder_pkg::*;

    logic                  clock;
    logic                  reset;
    logic                  load_req_valid;
    ADDR                   load_req_addr;
    LOAD_DATA_CACHE_PACKET ldp;
    MEM_COMMAND            cmd;
    ADDR                   maddr;
    MEM_TAG                mem_req_tag;
    MEM_TAG                mem_data_tag;
    MEM_BLOCK              mem_data;
    MSHR_FILL_PACKET       fp;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_load_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .load_req_valid         (load_req_valid),
        .load_req_addr          (load_req_addr),
        .load_data_cache_packet (ldp),
        .mem_command            (cmd),
        .mem_addr               (maddr),
        .mem_req_tag            (mem_req_tag),
        .mem_data_tag           (mem_data_tag),
        .mem_data               (mem_data),
        .fill_packet            (fp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: MSHRs as busy/sent flags, cache keyed by full block.
    bit          mb_busy  [4];
    bit          mb_sent  [4];
    logic [3:0]  mb_tag   [4];
    logic [28:0] mb_block [4];
    bit          ml_valid [32];
    logic [28:0] ml_block [32];
    logic [63:0] ml_data  [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_eval(
        output bit r_v, output bit r_full, output bit r_alloc, output bit idx_known,
        output int r_idx, output logic [63:0] r_data,
        output bit f_v, output int f_idx,
        output bit i_v, output int i_idx, output logic [28:0] i_blk);
        logic [28:0] blk;
        int line;
        bit found;
        blk = load_req_addr[31:3];
        line = int'(blk[4:0]);
        f_v = 0; f_idx = 0; i_v = 0; i_idx = 0; i_blk = '0;
        r_v = 0; r_full = 0; r_alloc = 0; idx_known = 0; r_idx = 0; r_data = '0;
        for (int i = 0; i < 4; i++)
            if (mb_busy[i] && mb_sent[i] && mem_data_tag != 4'd0 && mb_tag[i] == mem_data_tag) begin
                f_v = 1; f_idx = i;
            end
        for (int i = 3; i >= 0; i--)
            if (mb_busy[i] && !mb_sent[i]) begin
                i_v = 1; i_idx = i; i_blk = mb_block[i];
            end
        if (load_req_valid) begin
            if (f_v && mb_block[f_idx] == blk) begin
                r_v = 1; r_full = 1; r_data = mem_data;
            end else if (ml_valid[line] && ml_block[line] == blk) begin
                r_v = 1; r_full = 1; r_data = ml_data[line]; idx_known = 1; r_idx = 0;
            end else begin
                found = 0;
                for (int i = 0; i < 4; i++)
                    if (!found && mb_busy[i] && mb_block[i] == blk) begin
                        found = 1; r_v = 1; idx_known = 1; r_idx = i;
                    end
                for (int i = 0; i < 4; i++)
                    if (!found && !mb_busy[i]) begin
                        found = 1; r_v = 1; idx_known = 1; r_idx = i; r_alloc = 1;
                    end
            end
        end
    endfunction

    // Model state update on each clock edge; cleared on reset.
    always @(posedge clock or negedge reset) begin
        bit r_v, r_full, r_alloc, idx_known, f_v, i_v;
        int r_idx, f_idx, i_idx;
        logic [63:0] r_data;
        logic [28:0] i_blk;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mb_busy[i] <= 0; mb_sent[i] <= 0;
            end
            for (int i = 0; i < 32; i++) ml_valid[i] <= 0;
        end else begin
            model_eval(r_v, r_full, r_alloc, idx_known, r_idx, r_data, f_v, f_idx, i_v, i_idx, i_blk);
            if (f_v) begin
                ml_valid[int'(mb_block[f_idx][4:0])] <= 1;
                ml_block[int'(mb_block[f_idx][4:0])] <= mb_block[f_idx];
                ml_data[int'(mb_block[f_idx][4:0])]  <= mem_data;
                mb_busy[f_idx] <= 0;
            end
            if (i_v && mem_req_tag != 4'd0) begin
                mb_sent[i_idx] <= 1; mb_tag[i_idx] <= mem_req_tag;
            end
            if (r_alloc) begin
                mb_busy[r_idx] <= 1; mb_sent[r_idx] <= 0;
                mb_block[r_idx] <= load_req_addr[31:3];
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        bit r_v, r_full, r_alloc, idx_known, f_v, i_v;
        int r_idx, f_idx, i_idx;
        logic [63:0] r_data;
        logic [28:0] i_blk;
        if (!reset) begin
            chk("rst_resp_valid", 64'(ldp.valid), 64'd0);
            chk("rst_mem_cmd", 64'(cmd), 64'(MEM_NONE));
            chk("rst_fill_valid", 64'(fp.valid), 64'd0);
        end else begin
            model_eval(r_v, r_full, r_alloc, idx_known, r_idx, r_data, f_v, f_idx, i_v, i_idx, i_blk);
            chk("resp_valid", 64'(ldp.valid), 64'(r_v));
            if (r_v) begin
                chk("resp_mask", 64'(ldp.byte_mask), r_full ? 64'hFF : 64'h00);
                if (r_full) chk("resp_data", 64'(ldp.data), r_data);
                if (idx_known) chk("resp_idx", 64'(ldp.mshr_idx), 64'(r_idx));
            end
            chk("mem_cmd", 64'(cmd), i_v ? 64'(MEM_LOAD) : 64'(MEM_NONE));
            if (i_v) chk("mem_addr", 64'(maddr), 64'({i_blk, 3'b000}));
            chk("fill_valid", 64'(fp.valid), 64'(f_v));
            if (f_v) begin
                chk("fill_idx", 64'(fp.mshr_idx), 64'(f_idx));
                chk("fill_data", 64'(fp.data), mem_data);
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle();
        load_req_valid = 1'b0; load_req_addr = 32'd0;
        mem_req_tag = 4'd0; mem_data_tag = 4'd0; mem_data = 64'd0;
    endtask

    task automatic req(input logic [31:0] a);
        idle(); load_req_valid = 1'b1; load_req_addr = a;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b0; tick(); tick(); reset = 1'b1;
    endtask

    function automatic logic [3:0] fresh_tag();
        int s;
        bit used;
        logic [3:0] t;
        s = int'($urandom_range(1, 15));
        for (int k = 0; k < 15; k++) begin
            t = 4'(((s - 1 + k) % 15) + 1);
            used = 0;
            for (int j = 0; j < 4; j++)
                if (mb_busy[j] && mb_sent[j] && mb_tag[j] == t) used = 1;
            if (!used) return t;
        end
        return 4'd0;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b1;

        // Miss then hit
        req(32'h100); sample();
        chk("t1_alloc_valid", 64'(ldp.valid), 64'd1);
        chk("t1_alloc_idx", 64'(ldp.mshr_idx), 64'd0);
        chk("t1_alloc_mask", 64'(ldp.byte_mask), 64'd0);
        tick();
        idle(); mem_req_tag = 4'd3; sample();
        chk("t1_issue_cmd", 64'(cmd), 64'(MEM_LOAD));
        chk("t1_issue_addr", 64'(maddr), 64'h100);
        tick();
        idle(); mem_data_tag = 4'd3; mem_data = 64'h1122334455667788; sample();
        chk("t1_fill_valid", 64'(fp.valid), 64'd1);
        chk("t1_fill_idx", 64'(fp.mshr_idx), 64'd0);
        tick();
        req(32'h104); sample();
        chk("t1_hit_valid", 64'(ldp.valid), 64'd1);
        chk("t1_hit_mask", 64'(ldp.byte_mask), 64'hFF);
        chk("t1_hit_data1", 64'(ldp.data[1]), 64'h11223344);
        chk("t1_hit_data0", 64'(ldp.data[0]), 64'h55667788);
        tick();

        // Merge
        req(32'h200); sample();
        chk("merge_first_idx", 64'(ldp.mshr_idx), 64'd0);
        tick();
        req(32'h204); mem_req_tag = 4'd4; sample();
        chk("merge_second_valid", 64'(ldp.valid), 64'd1);
        chk("merge_second_idx", 64'(ldp.mshr_idx), 64'd0);
        chk("merge_issue_addr", 64'(maddr), 64'h200);
        tick();
        idle(); sample();
        chk("merge_single_load", 64'(cmd), 64'(MEM_NONE));
        tick();

        // Full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req(32'(k * 8)); sample();
            chk("full_alloc_idx", 64'(ldp.mshr_idx), 64'(k));
            tick();
        end
        req(32'h020); sample();
        chk("full_stall", 64'(ldp.valid), 64'd0);
        tick();
        idle(); mem_req_tag = 4'd1; tick();
        idle(); mem_req_tag = 4'd2; tick();
        req(32'h020); mem_data_tag = 4'd2; mem_data = 64'h0123456789ABCDEF; sample();
        chk("full_fill_idx", 64'(fp.mshr_idx), 64'd1);
        chk("full_same_cycle_stall", 64'(ldp.valid), 64'd0);
        tick();
        req(32'h020); sample();
        chk("full_next_valid", 64'(ldp.valid), 64'd1);
        chk("full_next_idx", 64'(ldp.mshr_idx), 64'd1);
        tick();

        // Reject and hold, then bypass
        do_reset();
        req(32'h300); tick();
        for (int c = 0; c < 3; c++) begin
            idle(); sample();
            chk("rej_hold_addr", 64'(maddr), 64'h300);
            tick();
        end
        idle(); mem_req_tag = 4'd5; sample();
        chk("rej_accept_cmd", 64'(cmd), 64'(MEM_LOAD));
        tick();
        idle(); sample();
        chk("rej_after_cmd", 64'(cmd), 64'(MEM_NONE));
        tick();
        req(32'h108); sample();
        chk("byp_alloc_idx", 64'(ldp.mshr_idx), 64'd1);
        tick();
        idle(); mem_req_tag = 4'd6; tick();
        req(32'h108); mem_data_tag = 4'd6; mem_data = 64'hAABBCCDDEEFF0011; sample();
        chk("byp_valid", 64'(ldp.valid), 64'd1);
        chk("byp_mask", 64'(ldp.byte_mask), 64'hFF);
        chk("byp_data1", 64'(ldp.data[1]), 64'hAABBCCDD);
        tick();

        // Reset mid-operation
        do_reset();
        req(32'h400); tick();
        idle(); mem_req_tag = 4'd7; tick();
        req(32'h400); reset = 1'b0; #1;
        chk("mid_rst_valid", 64'(ldp.valid), 64'd0);
        chk("mid_rst_cmd", 64'(cmd), 64'(MEM_NONE));
        chk("mid_rst_addr", 64'(maddr), 64'd0);
        chk("mid_rst_fill", 64'(fp.valid), 64'd0);
        tick(); tick();
        reset = 1'b1;
        req(32'h400); mem_data_tag = 4'd7; mem_data = 64'hDEADBEEFCAFEF00D; sample();
        chk("stale_fill_valid", 64'(fp.valid), 64'd0);
        chk("stale_no_hit_mask", 64'(ldp.byte_mask), 64'd0);
        tick();
        req(32'h400); sample();
        chk("stale_line_invalid", 64'(ldp.byte_mask), 64'd0);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [28:0] blk;
            logic [3:0] outs [$];
            int r;
            blk = 29'(($urandom_range(0, 3) << 5) | $urandom_range(0, 7));
            load_req_valid = ($urandom_range(0, 3) != 0);
            load_req_addr  = {blk, 1'($urandom_range(0, 1)), 2'b00};
            mem_req_tag    = ($urandom_range(0, 1) != 0) ? fresh_tag() : 4'd0;
            outs.delete();
            for (int j = 0; j < 4; j++)
                if (mb_busy[j] && mb_sent[j]) outs.push_back(mb_tag[j]);
            r = int'($urandom_range(0, 9));
            mem_data_tag = 4'd0;
            if (r < 4 && outs.size() > 0)
                mem_data_tag = outs[$urandom_range(0, outs.size() - 1)];
            else if (r == 4)
                mem_data_tag = fresh_tag();
            mem_data = {$urandom, $urandom};
            tick();
        end

        idle();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
